// File: rtl/tlb_assoc.sv
// tlb_assoc: set-associative TLB with ASID tagging, global pages, per-set
// round-robin replacement, a single-cycle flush-all and a multi-cycle
// flush-by-ASID sweep. Lookups are combinational against the current array
// contents and the response is registered one cycle later.
module tlb_assoc #(
  parameter int VA_WIDTH   = 32,
  parameter int PA_WIDTH   = 32,
  parameter int PAGE_BITS  = 12,
  parameter int SETS       = 64,
  parameter int WAYS       = 4,
  parameter int ASID_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [VA_WIDTH-1:0]           req_vaddr,
  input  logic [ASID_WIDTH-1:0]         req_asid,
  output logic                          resp_valid,
  output logic                          resp_hit,
  output logic [PA_WIDTH-1:0]           resp_paddr,
  input  logic                          fill_valid,
  output logic                          fill_ready,
  input  logic [VA_WIDTH-1:0]           fill_vaddr,
  input  logic [ASID_WIDTH-1:0]         fill_asid,
  input  logic [PA_WIDTH-PAGE_BITS-1:0] fill_ppn,
  input  logic                          fill_global,
  input  logic                          flush_all,
  input  logic                          flush_asid_valid,
  input  logic [ASID_WIDTH-1:0]         flush_asid,
  output logic                          busy
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = VA_WIDTH - PAGE_BITS - IDX_W;
  localparam int PPN_W = PA_WIDTH - PAGE_BITS;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      sweep_idx_reg, sweep_idx_next;
  logic [ASID_WIDTH-1:0] sweep_asid_reg, sweep_asid_next;

  // Entry storage. Valid bits live in flops so flush_all can clear them in one edge.
  logic [WAYS-1:0]       valid_bits [SETS];
  logic [WAYS-1:0]       glob_bits  [SETS];
  logic [ASID_WIDTH-1:0] asid_mem   [SETS][WAYS];
  logic [TAG_W-1:0]      tag_mem    [SETS][WAYS];
  logic [PPN_W-1:0]      ppn_mem    [SETS][WAYS];
  logic [WAY_W-1:0]      victim_ptr [SETS];

  logic [IDX_W-1:0] req_set, fill_set;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic [WAYS-1:0]  req_match, fill_match, fill_free, sweep_kill;
  logic [WAY_W-1:0] hit_way, fill_way, next_victim;
  logic             req_hit, req_fire, fill_fire, use_victim;
  logic             unused_fill_offset;

  assign busy       = (state_reg == SWEEP);
  assign fill_ready = !busy;
  assign req_ready  = !busy && !fill_valid;
  assign req_fire   = req_valid && req_ready;
  // flush_all outranks a fill on the same edge; the fill is dropped.
  assign fill_fire  = fill_valid && fill_ready && !flush_all;

  assign req_set  = req_vaddr[PAGE_BITS +: IDX_W];
  assign req_tag  = req_vaddr[VA_WIDTH-1 -: TAG_W];
  assign fill_set = fill_vaddr[PAGE_BITS +: IDX_W];
  assign fill_tag = fill_vaddr[VA_WIDTH-1 -: TAG_W];
  assign unused_fill_offset = ^fill_vaddr[PAGE_BITS-1:0];

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign req_match[gi] = valid_bits[req_set][gi]
                          && (tag_mem[req_set][gi] == req_tag)
                          && (glob_bits[req_set][gi] || (asid_mem[req_set][gi] == req_asid));
      // A fill aliases an existing entry if either side is global.
      assign fill_match[gi] = valid_bits[fill_set][gi]
                           && (tag_mem[fill_set][gi] == fill_tag)
                           && (glob_bits[fill_set][gi] || fill_global
                               || (asid_mem[fill_set][gi] == fill_asid));
      assign fill_free[gi]  = !valid_bits[fill_set][gi];
      assign sweep_kill[gi] = !glob_bits[sweep_idx_reg][gi]
                           && (asid_mem[sweep_idx_reg][gi] == sweep_asid_reg);
    end
  endgenerate

  assign req_hit = |req_match;

  // Lowest-numbered matching way wins the lookup.
  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (req_match[w]) hit_way = WAY_W'(w);
    end
  end

  // Fill target: matching way, else lowest free way, else round-robin victim.
  always_comb begin
    fill_way   = victim_ptr[fill_set];
    use_victim = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (fill_free[w]) begin
        fill_way   = WAY_W'(w);
        use_victim = 1'b0;
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (fill_match[w]) begin
        fill_way   = WAY_W'(w);
        use_victim = 1'b0;
      end
    end
  end

  assign next_victim = (victim_ptr[fill_set] == WAY_W'(WAYS - 1)) ? '0
                                                                    : victim_ptr[fill_set] + 1'b1;

  // Flush-by-ASID next state: latch ASID on start, walk every set once.
  always_comb begin
    state_next      = state_reg;
    sweep_idx_next  = sweep_idx_reg;
    sweep_asid_next = sweep_asid_reg;
    if (flush_all) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (flush_asid_valid) begin
            state_next      = SWEEP;
            sweep_idx_next  = '0;
            sweep_asid_next = flush_asid;
          end
        end
        SWEEP: begin
          sweep_idx_next = sweep_idx_reg + 1'b1;
          if (sweep_idx_reg == IDX_W'(SETS - 1)) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Sweep FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      sweep_idx_reg  <= '0;
      sweep_asid_reg <= '0;
    end else begin
      state_reg      <= state_next;
      sweep_idx_reg  <= sweep_idx_next;
      sweep_asid_reg <= sweep_asid_next;
    end
  end

  // Valid bits and victim pointers: reset/flush_all clear, sweep invalidates, fill sets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_bits[s] <= '0;
        victim_ptr[s] <= '0;
      end
    end else if (flush_all) begin
      for (int s = 0; s < SETS; s++) begin
        valid_bits[s] <= '0;
        victim_ptr[s] <= '0;
      end
    end else if (state_reg == SWEEP) begin
      valid_bits[sweep_idx_reg] <= valid_bits[sweep_idx_reg] & ~sweep_kill;
    end else if (fill_fire) begin
      valid_bits[fill_set][fill_way] <= 1'b1;
      if (use_victim) victim_ptr[fill_set] <= next_victim;
    end
  end

  // Entry payload written on an accepted fill; meaningless while invalid.
  always_ff @(posedge clk) begin
    if (fill_fire) begin
      glob_bits[fill_set][fill_way] <= fill_global;
      asid_mem[fill_set][fill_way]  <= fill_asid;
      tag_mem[fill_set][fill_way]   <= fill_tag;
      ppn_mem[fill_set][fill_way]   <= fill_ppn;
    end
  end

  // Registered lookup response; hit/paddr hold between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_paddr <= '0;
    end else begin
      resp_valid <= req_fire;
      if (req_fire) begin
        resp_hit   <= req_hit;
        resp_paddr <= req_hit ? {ppn_mem[req_set][hit_way], req_vaddr[PAGE_BITS-1:0]} : '0;
      end
    end
  end
endmodule

// File: tb/tb_tlb_assoc.sv
// tb_tlb_assoc: directed table vectors, hand-written corner sequences and a
// randomized phase checked against a behavioural TLB model.
`timescale 1ns/1ps
module tb_tlb_assoc;
  localparam int VA_WIDTH   = 32;
  localparam int PA_WIDTH   = 32;
  localparam int PAGE_BITS  = 12;
  localparam int SETS       = 64;
  localparam int WAYS       = 4;
  localparam int ASID_WIDTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_vaddr = '0;
  logic [7:0]  req_asid = '0;
  logic        resp_valid, resp_hit;
  logic [31:0] resp_paddr;
  logic        fill_valid = 1'b0, fill_ready;
  logic [31:0] fill_vaddr = '0;
  logic [7:0]  fill_asid = '0;
  logic [19:0] fill_ppn = '0;
  logic        fill_global = 1'b0;
  logic        flush_all = 1'b0;
  logic        flush_asid_valid = 1'b0;
  logic [7:0]  flush_asid = '0;
  logic        busy;

  tlb_assoc #(
    .VA_WIDTH(VA_WIDTH), .PA_WIDTH(PA_WIDTH), .PAGE_BITS(PAGE_BITS),
    .SETS(SETS), .WAYS(WAYS), .ASID_WIDTH(ASID_WIDTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr), .req_asid(req_asid),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_paddr(resp_paddr),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_vaddr(fill_vaddr),
    .fill_asid(fill_asid), .fill_ppn(fill_ppn), .fill_global(fill_global),
    .flush_all(flush_all), .flush_asid_valid(flush_asid_valid), .flush_asid(flush_asid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: per set, WAYS slots plus a replacement pointer.
  bit          m_valid [SETS][WAYS];
  bit          m_glob  [SETS][WAYS];
  logic [7:0]  m_asid  [SETS][WAYS];
  logic [13:0] m_tag   [SETS][WAYS];
  logic [19:0] m_ppn   [SETS][WAYS];
  int          m_victim[SETS];

  typedef struct packed {
    logic [31:0] va;
    logic [7:0]  asid;
    logic        hit;
    logic [31:0] pa;
  } vec_t;
  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_victim[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  function automatic void model_lookup(input logic [31:0] va, input logic [7:0] a,
                                       output bit hit, output logic [31:0] pa);
    int s;
    s   = int'(va[17:12]);
    hit = 1'b0;
    pa  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && m_valid[s][w] && m_tag[s][w] == va[31:18] && (m_glob[s][w] || m_asid[s][w] == a)) begin
        hit = 1'b1;
        pa  = {m_ppn[s][w], va[11:0]};
      end
    end
  endfunction

  function automatic void model_fill(input logic [31:0] va, input logic [7:0] a,
                                     input logic [19:0] p, input bit g);
    int s, slot;
    s    = int'(va[17:12]);
    slot = -1;
    for (int w = 0; w < WAYS; w++)
      if (slot < 0 && m_valid[s][w] && m_tag[s][w] == va[31:18] && (m_glob[s][w] || g || m_asid[s][w] == a))
        slot = w;
    for (int w = 0; w < WAYS; w++)
      if (slot < 0 && !m_valid[s][w]) slot = w;
    if (slot < 0) begin
      slot = m_victim[s];
      m_victim[s] = (m_victim[s] + 1) % WAYS;
    end
    m_valid[s][slot] = 1'b1;
    m_glob[s][slot]  = g;
    m_asid[s][slot]  = a;
    m_tag[s][slot]   = va[31:18];
    m_ppn[s][slot]   = p;
  endfunction

  function automatic void model_flush_asid(input logic [7:0] a);
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (!m_glob[s][w] && m_asid[s][w] == a) m_valid[s][w] = 1'b0;
  endfunction

  function automatic logic [31:0] va5(input int t);
    logic [13:0] tg;
    tg = 14'(t);
    return {tg, 6'd5, 12'h123};
  endfunction

  function automatic logic [31:0] rand_va();
    logic [13:0] tg;
    logic [5:0]  st;
    logic [11:0] off;
    tg  = 14'($urandom_range(0, 7));
    st  = ($urandom_range(0, 1) == 0) ? 6'd2 : 6'd5;
    off = 12'($urandom);
    return {tg, st, off};
  endfunction

  // All transaction tasks start and end 1ns after a rising edge.
  task automatic lookup_exp(input string name, input logic [31:0] va, input logic [7:0] a,
                            input bit eh, input logic [31:0] ep);
    req_valid = 1'b1; req_vaddr = va; req_asid = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({name, ".resp_valid"}, {31'b0, resp_valid}, 32'd1);
    check({name, ".resp_hit"},   {31'b0, resp_hit},   {31'b0, eh});
    check({name, ".resp_paddr"}, resp_paddr, ep);
    $display("lookup %s va=%h asid=%0d hit=%0b pa=%h", name, va, a, resp_hit, resp_paddr);
  endtask

  task automatic lookup_model(input string name, input logic [31:0] va, input logic [7:0] a);
    bit eh;
    logic [31:0] ep;
    model_lookup(va, a, eh, ep);
    lookup_exp(name, va, a, eh, ep);
  endtask

  task automatic do_fill(input logic [31:0] va, input logic [7:0] a, input logic [19:0] p, input bit g);
    fill_valid = 1'b1; fill_vaddr = va; fill_asid = a; fill_ppn = p; fill_global = g;
    #1;
    check("fill.fill_ready", {31'b0, fill_ready}, 32'd1);
    @(posedge clk); #1;
    fill_valid = 1'b0;
    model_fill(va, a, p, g);
    $display("fill va=%h asid=%0d ppn=%h global=%0b", va, a, p, g);
  endtask

  task automatic do_flush_all();
    flush_all = 1'b1;
    @(posedge clk); #1;
    flush_all = 1'b0;
    model_clear();
    check("flush_all.busy", {31'b0, busy}, 32'd0);
    $display("flush_all");
  endtask

  // Sweep: busy for exactly SETS cycles, nothing accepted, restart attempt ignored.
  task automatic do_sweep(input logic [7:0] a);
    flush_asid_valid = 1'b1; flush_asid = a;
    @(posedge clk); #1;
    flush_asid_valid = 1'b0;
    req_valid = 1'b1; req_vaddr = rand_va(); req_asid = a;
    for (int i = 0; i < SETS; i++) begin
      flush_asid_valid = (i == 5);
      flush_asid = a ^ 8'h01;
      #1;
      check($sformatf("sweep%0d.busy", i), {31'b0, busy}, 32'd1);
      check($sformatf("sweep%0d.req_ready", i), {31'b0, req_ready}, 32'd0);
      check($sformatf("sweep%0d.fill_ready", i), {31'b0, fill_ready}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("sweep%0d.resp_valid", i), {31'b0, resp_valid}, 32'd0);
    end
    flush_asid_valid = 1'b0;
    req_valid = 1'b0;
    check("sweep_end.busy", {31'b0, busy}, 32'd0);
    model_flush_asid(a);
    $display("flush_asid asid=%0d done", a);
  endtask

  task automatic test_table();
    vt[0] = '{va: 32'h0001_2345, asid: 8'd3,    hit: 1'b1, pa: 32'hABCD_E345};
    vt[1] = '{va: 32'h0001_2345, asid: 8'd4,    hit: 1'b0, pa: 32'h0};
    vt[2] = '{va: 32'h0001_2FFF, asid: 8'd3,    hit: 1'b1, pa: 32'hABCD_EFFF};
    vt[3] = '{va: 32'h0001_3345, asid: 8'd3,    hit: 1'b0, pa: 32'h0};
    vt[4] = '{va: 32'h0044_0ABC, asid: 8'd9,    hit: 1'b0, pa: 32'h0};
    vt[5] = '{va: 32'h0040_0ABC, asid: 8'h55,   hit: 1'b1, pa: 32'h1234_5ABC};
    do_fill(32'h0001_2000, 8'd3, 20'hABCDE, 1'b0);
    do_fill(32'h0040_0000, 8'd9, 20'h12345, 1'b1);
    for (int i = 0; i < 6; i++)
      lookup_exp($sformatf("vec%0d", i), vt[i].va, vt[i].asid, vt[i].hit, vt[i].pa);
    @(posedge clk); #1;
    check("hold.resp_valid", {31'b0, resp_valid}, 32'd0);
    check("hold.resp_hit",   {31'b0, resp_hit},   32'd1);
    check("hold.resp_paddr", resp_paddr, 32'h1234_5ABC);
  endtask

  task automatic test_replace();
    for (int t = 1; t <= 6; t++) do_fill(va5(t), 8'd1, 20'(32'h100 + t), 1'b0);
    lookup_exp("rr_tag1", va5(1), 8'd1, 1'b0, 32'h0);
    lookup_exp("rr_tag2", va5(2), 8'd1, 1'b0, 32'h0);
    lookup_exp("rr_tag5", va5(5), 8'd1, 1'b1, 32'h0010_5123);
    lookup_exp("rr_tag6", va5(6), 8'd1, 1'b1, 32'h0010_6123);
    do_fill(va5(4), 8'd1, 20'h001F4, 1'b0);
    lookup_exp("rr_over4", va5(4), 8'd1, 1'b1, 32'h001F_4123);
    lookup_exp("rr_keep3", va5(3), 8'd1, 1'b1, 32'h0010_3123);
  endtask

  task automatic test_asid_sweep();
    do_fill(32'h0080_0000, 8'd7, 20'h77001, 1'b0);
    do_fill(32'h00C0_1000, 8'd7, 20'h77002, 1'b1);
    do_fill(32'h0100_2000, 8'd8, 20'h88003, 1'b0);
    do_sweep(8'd7);
    lookup_exp("sw_nonglobal", 32'h0080_0ABC, 8'd7, 1'b0, 32'h0);
    lookup_exp("sw_global",    32'h00C0_1ABC, 8'd7, 1'b1, 32'h7700_2ABC);
    lookup_exp("sw_other",     32'h0100_2ABC, 8'd8, 1'b1, 32'h8800_3ABC);
  endtask

  task automatic test_abort();
    flush_asid_valid = 1'b1; flush_asid = 8'h99;
    @(posedge clk); #1;
    flush_asid_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("abort.busy_before", {31'b0, busy}, 32'd1);
    do_flush_all();
    lookup_exp("abort_abcde",  32'h0001_2345, 8'd3, 1'b0, 32'h0);
    lookup_exp("abort_global", 32'h00C0_1ABC, 8'd7, 1'b0, 32'h0);
    lookup_exp("abort_other",  32'h0100_2ABC, 8'd8, 1'b0, 32'h0);
    lookup_exp("abort_tag3",   va5(3),        8'd1, 1'b0, 32'h0);
  endtask

  task automatic test_b2b();
    logic [31:0] bb [8];
    bit eh;
    logic [31:0] ep;
    do_fill(va5(1), 8'd2, 20'h00201, 1'b0);
    do_fill(va5(2), 8'd2, 20'h00202, 1'b0);
    bb = '{va5(1), va5(2), va5(3), va5(1), va5(3), va5(2), va5(3), va5(1)};
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1; req_vaddr = bb[c]; req_asid = 8'd2;
      fill_valid = (c == 3); fill_vaddr = va5(3); fill_asid = 8'd2; fill_ppn = 20'h00203; fill_global = 1'b0;
      #1;
      check($sformatf("b2b%0d.req_ready", c), {31'b0, req_ready}, (c == 3) ? 32'd0 : 32'd1);
      model_lookup(bb[c], 8'd2, eh, ep);
      @(posedge clk); #1;
      if (c == 3) model_fill(va5(3), 8'd2, 20'h00203, 1'b0);
      check($sformatf("b2b%0d.resp_valid", c), {31'b0, resp_valid}, (c == 3) ? 32'd0 : 32'd1);
      if (c != 3) begin
        check($sformatf("b2b%0d.resp_hit", c), {31'b0, resp_hit}, {31'b0, eh});
        check($sformatf("b2b%0d.resp_paddr", c), resp_paddr, ep);
      end
      $display("b2b slot %0d va=%h valid=%0b hit=%0b pa=%h", c, bb[c], resp_valid, resp_hit, resp_paddr);
    end
    req_valid = 1'b0;
    fill_valid = 1'b0;
    lookup_exp("b2b_after", va5(3), 8'd2, 1'b1, 32'h0020_3123);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int op;
      logic [31:0] va;
      logic [7:0]  a;
      op = $urandom_range(0, 99);
      va = rand_va();
      a  = 8'($urandom_range(0, 3));
      if (op < 60)      lookup_model($sformatf("rnd%0d", n), va, a);
      else if (op < 93) do_fill(va, a, 20'($urandom), ($urandom_range(0, 5) == 0));
      else if (op < 97) do_flush_all();
      else              do_sweep(a);
    end
  endtask

  task automatic test_async_reset();
    do_fill(va5(1), 8'd5, 20'h00555, 1'b0);
    req_valid = 1'b1; req_vaddr = va5(1); req_asid = 8'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_resp.pre_hit", {31'b0, resp_hit}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_resp.resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp.resp_hit",   {31'b0, resp_hit},   32'd0);
    check("rst_resp.resp_paddr", resp_paddr, 32'h0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    model_clear();
    flush_asid_valid = 1'b1; flush_asid = 8'd5;
    @(posedge clk); #1;
    flush_asid_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("rst_sweep.pre_busy", {31'b0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_sweep.busy", {31'b0, busy}, 32'd0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_sweep.busy_after", {31'b0, busy}, 32'd0);
    lookup_exp("rst_cleared", va5(1), 8'd5, 1'b0, 32'h0);
  endtask

  initial begin
    model_clear();
    #12;
    check("reset.resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset.resp_hit",   {31'b0, resp_hit},   32'd0);
    check("reset.resp_paddr", resp_paddr, 32'h0);
    check("reset.busy",       {31'b0, busy},       32'd0);
    check("reset.req_ready",  {31'b0, req_ready},  32'd1);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    lookup_exp("cold_miss", 32'h0001_2345, 8'd3, 1'b0, 32'h0);
    @(posedge clk); #1;
    check("cold_miss.one_cycle", {31'b0, resp_valid}, 32'd0);

    test_table();
    test_replace();
    test_asid_sweep();
    test_abort();
    test_b2b();
    test_random();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tlb_assoc.md
# tlb_assoc

Parametrised set-associative TLB with address-space identifiers (ASIDs), global pages, per-set round-robin replacement and flush support. It is the successor to the fixed 64×4 lookup/update TLB and sits beside the L1 in the VIPT path. The MMU fills it, and the pipeline looks addresses up through a valid/ready request with a registered response. OS-level invalidation is either a single-cycle flush-all or a multi-cycle flush-by-ASID sweep.

## Interface
Parameters:
- VA_WIDTH, 32, virtual address width
- PA_WIDTH, 32, physical address width
- PAGE_BITS, 12, page-offset width
- SETS, 64, number of sets (power of two, ≥2); IDX_W = log2(SETS)
- WAYS, 4, associativity (power of two, ≥1)
- ASID_WIDTH, 8, ASID width
- Derived widths: TAG_W = VA_WIDTH-PAGE_BITS-IDX_W; PPN_W = PA_WIDTH-PAGE_BITS

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  1  lookup request
- req_ready  out  1  = !busy && !fill_valid
- req_vaddr  in  VA_WIDTH  lookup virtual address
- req_asid  in  ASID_WIDTH  lookup ASID
- resp_valid  out  1  response strobe, one cycle per accepted request
- resp_hit  out  1  translation found
- resp_paddr  out  PA_WIDTH  {ppn, vaddr offset} on hit, 0 on miss
- fill_valid  in  1  MMU fill request
- fill_ready  out  1  = !busy
- fill_vaddr  in  VA_WIDTH  fill virtual address
- fill_asid  in  ASID_WIDTH  fill ASID
- fill_ppn  in  PPN_W  physical page number
- fill_global  in  1  entry matches any ASID
- flush_all  in  1  invalidate every entry
- flush_asid_valid  in  1  start flush-by-ASID sweep
- flush_asid  in  ASID_WIDTH  ASID to flush
- busy  out  1  flush-by-ASID sweep in progress

## Operation
- Entry fields: valid, global, asid, tag, ppn.
- Address split: set = vaddr[PAGE_BITS +: IDX_W]; tag = vaddr[VA_WIDTH-1 -: TAG_W].
- Match rule: valid && tag equal && (global || asid equal).
- Lookup: accepted when req_valid && req_ready. The way search and response use array contents before any same-edge write. If several ways match, the lowest-numbered way wins.
- Fill: accepted when fill_valid && fill_ready. Target way is chosen in this order:
  1. lowest matching way (same tag, same ASID or either side global) — overwrite in place;
  2. else lowest invalid way;
  3. else the set's round-robin victim pointer.
- The victim pointer (log2(WAYS) bits per set, wraps WAYS-1→0) advances only when rule 3 is used.
- flush_all: clears every valid bit and every victim pointer on that edge. It is honoured even when busy; a running sweep is aborted and busy drops the next cycle.
- Flush-by-ASID FSM:
  - IDLE: flush_asid_valid (with flush_all low) → latch the ASID, set counter to 0, go to SWEEP.
  - SWEEP: each cycle, clear valid on non-global entries of set[counter] whose asid equals the latched ASID; counter+1. After set SETS-1 is processed → IDLE.
  - flush_asid_valid is ignored while in SWEEP.
- Per-edge priority: reset > flush_all > sweep / flush_asid start > fill > lookup.

## Timing
- Reset values: resp_valid=0, resp_hit=0, resp_paddr=0, busy=0, FSM=IDLE; all valid bits and victim pointers 0.
- Lookup latency is 1 cycle: accept at edge N, response valid after edge N+1 for exactly one cycle. resp_hit and resp_paddr hold their values when resp_valid=0. Full throughput is one lookup per cycle.
- Fill writes at its accept edge; a lookup accepted on the next cycle sees it.
- busy rises the cycle after flush_asid_valid is sampled and stays high for exactly SETS cycles. While busy, req_ready=0 and fill_ready=0.
- A lookup accepted the cycle before a flush returns pre-flush contents.
- Reset asserted mid-sweep or mid-response: all outputs go to reset values immediately (asynchronously).

## Test plan
- Reset, then lookup vaddr 0x0001_2345, asid 3 → resp_valid one cycle later; resp_hit=0, resp_paddr=0.
- Fill vaddr 0x0001_2000, asid 3, ppn 0xABCDE, global=0. Lookup 0x0001_2345 with asid 3 → hit, paddr 0xABCDE345. Same address with asid 4 → miss.
- Five fills with distinct tags into set 5 (4 ways) → the fifth replaces way 0. A sixth distinct fill replaces way 1. Lookup of the first tag misses; lookup of the fifth tag hits.
- Fill asid 7 non-global and asid 7 global entries, then flush_asid_valid with asid 7 → busy high for 64 cycles, req_ready low throughout. Afterwards the non-global entry misses and the global entry still hits.
- Start the sweep; at sweep cycle 10 pulse flush_all → busy low next cycle, every prior entry misses.
- Back-to-back lookups for 8 cycles → 8 consecutive resp_valid pulses with in-order results. Raise fill_valid in cycle 4 → req_ready=0 that cycle and no response in the following slot.
